pipe_ctrl: RTL and testbench

//  Pipeline sequencer between ex and the front-end (pc_reg, if_id, id_ex). Arbitrates

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_cnt.sv | 36 +++
 rtl/pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Front-end state encodings, the flush NOP and a counter width helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_e;

    // Instruction loaded into if_id/id_ex while a stage is flushed (addi x0,x0,0).
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipe_cnt.sv
// Loadable down-counter that stops at zero.
// Used to time the multi-cycle flush that follows a taken jump.
module pipe_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates ex/memory/debug requests into PC redirect,
// per-stage hold and flush for pc_reg, if_id and id_ex.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_req_mem_i,
    input  logic        hold_req_ext_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        halted_o,
    output logic        stall_timeout_o
);

    localparam int unsigned FW = cnt_width(FLUSH_CYCLES);
    localparam int unsigned SW = cnt_width(STALL_TIMEOUT);

    pipe_state_e   state_q, state_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          pend_vld_q, pend_vld_d;
    logic [31:0]   pend_addr_q, pend_addr_d;

    logic [FW-1:0] fl_cnt;
    logic          fl_load;
    logic          fl_dec;

    logic          any_hold;
    logic          hold;
    logic          flush;
    logic          issue;
    logic [31:0]   issue_addr;
    logic          timeout;

    assign any_hold = hold_flag_ex_i | hold_req_mem_i;

    pipe_cnt #(
        .WIDTH (FW)
    ) u_flush_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (fl_load),
        .load_val_i (FW'(FLUSH_CYCLES - 1)),
        .dec_i      (fl_dec),
        .cnt_o      (fl_cnt)
    );

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        hold        = 1'b0;
        flush       = 1'b0;
        issue       = 1'b0;
        issue_addr  = '0;
        timeout     = 1'b0;
        fl_load     = 1'b0;
        fl_dec      = 1'b0;

        case (state_q)
            // RUN and STALL share arbitration; stall_cnt_q is zero in RUN.
            ST_RUN, ST_STALL: begin
                if (hold_req_ext_i) begin
                    hold        = 1'b1;
                    state_d     = ST_HALT;
                    stall_cnt_d = '0;
                    if (jump_en_i) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (jump_en_i && !((state_q == ST_STALL) && hold_flag_ex_i)) begin
                    issue       = 1'b1;
                    issue_addr  = jump_addr_i;
                    stall_cnt_d = '0;
                end else if (any_hold) begin
                    hold        = 1'b1;
                    state_d     = ST_STALL;
                    timeout     = (stall_cnt_q == SW'(STALL_TIMEOUT - 1));
                    stall_cnt_d = (stall_cnt_q == SW'(STALL_TIMEOUT)) ? stall_cnt_q
                                                                      : stall_cnt_q + SW'(1);
                end else begin
                    state_d     = ST_RUN;
                    stall_cnt_d = '0;
                end
            end

            ST_FLUSH: begin
                flush  = 1'b1;
                fl_dec = 1'b1;
                if (fl_cnt <= FW'(1)) begin
                    state_d = hold_req_ext_i ? ST_HALT : ST_RUN;
                end
            end

            ST_HALT: begin
                hold = 1'b1;
                if (hold_req_ext_i) begin
                    if (jump_en_i && !pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (pend_vld_q) begin
                    hold        = 1'b0;
                    issue       = 1'b1;
                    issue_addr  = pend_addr_q;
                    pend_vld_d  = 1'b0;
                    pend_addr_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (issue) begin
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                fl_load = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign jump_en_o       = ~rst & issue;
    assign jump_addr_o     = (~rst & issue) ? issue_addr : '0;
    assign hold_pc_o       = ~rst & hold;
    assign hold_if_id_o    = ~rst & hold;
    assign hold_id_ex_o    = ~rst & hold;
    assign flush_if_id_o   = ~rst & flush;
    assign flush_id_ex_o   = ~rst & flush;
    assign halted_o        = ~rst & (state_q == ST_HALT);
    assign stall_timeout_o = ~rst & timeout;

    a_if_id_excl: assert property (@(posedge clk) !(hold_if_id_o && flush_if_id_o));
    a_id_ex_excl: assert property (@(posedge clk) !(hold_id_ex_o && flush_id_ex_o));
    a_jump_flush: assert property (@(posedge clk) jump_en_o |-> (flush_if_id_o && flush_id_ex_o));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_pipe_ctrl;

    localparam int unsigned FC = 2;
    localparam int unsigned ST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_req_mem_i;
    logic        hold_req_ext_i;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        halted_o;
    logic        stall_timeout_o;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FLUSH_CYCLES  (FC),
        .STALL_TIMEOUT (ST)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_en_i       (jump_en_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_ex_i  (hold_flag_ex_i),
        .hold_req_mem_i  (hold_req_mem_i),
        .hold_req_ext_i  (hold_req_ext_i),
        .jump_en_o       (jump_en_o),
        .jump_addr_o     (jump_addr_o),
        .hold_pc_o       (hold_pc_o),
        .hold_if_id_o    (hold_if_id_o),
        .hold_id_ex_o    (hold_id_ex_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .halted_o        (halted_o),
        .stall_timeout_o (stall_timeout_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: remaining flush cycles, consecutive held cycles, halt flag, parked jumps.
    int          m_flush_left;
    int          m_stall_run;
    bit          m_halted;
    logic [31:0] parked[$];

    bit          e_jump, e_hold, e_flush, e_halted, e_to;
    logic [31:0] e_addr;

    function automatic void model_issue(input logic [31:0] a);
        e_jump       = 1'b1;
        e_addr       = a;
        e_flush      = 1'b1;
        m_flush_left = int'(FC) - 1;
        m_stall_run  = 0;
    endfunction

    function automatic void model_eval();
        e_jump = 0; e_hold = 0; e_flush = 0; e_to = 0; e_addr = '0;
        e_halted = 0;
        if (rst) begin
            m_flush_left = 0;
            m_stall_run  = 0;
            m_halted     = 0;
            parked.delete();
            return;
        end
        e_halted = m_halted;
        if (m_flush_left > 0) begin
            e_flush = 1;
            m_flush_left--;
            if (m_flush_left == 0 && hold_req_ext_i) m_halted = 1;
        end else if (m_halted) begin
            e_hold = 1;
            if (hold_req_ext_i) begin
                if (jump_en_i && parked.size() == 0) parked.push_back(jump_addr_i);
            end else if (parked.size() != 0) begin
                e_hold   = 0;
                model_issue(parked.pop_front());
                m_halted = 0;
            end else begin
                m_halted = 0;
            end
        end else if (hold_req_ext_i) begin
            e_hold      = 1;
            m_halted    = 1;
            m_stall_run = 0;
            if (jump_en_i) parked.push_back(jump_addr_i);
        end else if (jump_en_i && !(m_stall_run > 0 && hold_flag_ex_i)) begin
            model_issue(jump_addr_i);
        end else if (hold_flag_ex_i || hold_req_mem_i) begin
            e_hold = 1;
            m_stall_run++;
            e_to = (m_stall_run == int'(ST));
        end else begin
            m_stall_run = 0;
        end
    endfunction

    logic s_jump, s_hold, s_flush, s_halted, s_to;
    logic [31:0] s_addr;

    task automatic step();
        @(negedge clk);
        model_eval();
        s_jump = jump_en_o; s_addr = jump_addr_o; s_hold = hold_pc_o;
        s_flush = flush_if_id_o; s_halted = halted_o; s_to = stall_timeout_o;
        check_val("ctl",
            {24'd0, jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
             flush_if_id_o, flush_id_ex_o, halted_o, stall_timeout_o},
            {24'd0, e_jump, e_hold, e_hold, e_hold, e_flush, e_flush, e_halted, e_to});
        check_val("addr", jump_addr_o, e_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic j, input logic [31:0] a,
                         input logic ex, input logic mem, input logic ext);
        rst = r; jump_en_i = j; jump_addr_i = a;
        hold_flag_ex_i = ex; hold_req_mem_i = mem; hold_req_ext_i = ext;
    endtask

    initial begin
        int holds, flushes, pulses, pulse_at, bad300;
        logic ext_lvl, mem_lvl;

        // Reset with every input high.
        drive(1, 1, 32'hFFFF_FFFF, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_outs", {27'd0, s_jump, s_hold, s_flush, s_halted, s_to}, 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_val("post_rst_outs", {27'd0, s_jump, s_hold, s_flush, s_halted, s_to}, 32'd0);

        // Taken jump, second jump during flush ignored.
        drive(0, 1, 32'h0000_0100, 0, 0, 0);
        step();
        check_val("t2_jump", {31'd0, s_jump}, 32'd1);
        check_val("t2_addr", s_addr, 32'h100);
        check_val("t2_flushN", {31'd0, s_flush}, 32'd1);
        drive(0, 1, 32'h0000_0180, 0, 0, 0);
        step();
        check_val("t2_flushN1", {31'd0, s_flush}, 32'd1);
        check_val("t2_ignored", {31'd0, s_jump}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_val("t2_flushN2", {31'd0, s_flush}, 32'd0);

        // Memory stall 5 cycles, then 10 cycles for the watchdog.
        holds = 0; flushes = 0;
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(); holds += int'(s_hold); flushes += int'(s_flush);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(); holds += int'(s_hold); flushes += int'(s_flush);
        end
        check_val("t3_holds", holds, 5);
        check_val("t3_noflush", flushes, 0);
        pulses = 0; pulse_at = -1;
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            if (s_to) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        check_val("t3_pulses", pulses, 1);
        check_val("t3_pulse_at", pulse_at, 4);
        drive(0, 0, 0, 0, 0, 0);
        step();

        // Jump parked at halt entry; later jump in HALT dropped.
        bad300 = 0;
        drive(0, 1, 32'h0000_0200, 0, 0, 1);
        step();
        check_val("t4_nojump", {31'd0, s_jump}, 32'd0);
        for (int i = 1; i < 6; i++) begin
            drive(0, (i == 2), 32'h0000_0300, 0, 0, 1);
            step();
            check_val("t4_halted", {31'd0, s_halted}, 32'd1);
            if (s_jump && s_addr == 32'h300) bad300++;
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_val("t4_rel_jump", {31'd0, s_jump}, 32'd1);
        check_val("t4_rel_addr", s_addr, 32'h200);
        for (int i = 0; i < 4; i++) begin
            step();
            if (s_jump && s_addr == 32'h300) bad300++;
        end
        check_val("t4_no300", bad300, 0);

        // Reset mid-FLUSH and mid-HALT with a parked jump.
        drive(0, 1, 32'h0000_0400, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_val("t5_flush_stop", {31'd0, s_flush}, 32'd0);
        drive(0, 1, 32'h0000_0500, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(1, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        check_val("t5_nojump", {31'd0, s_jump}, 32'd0);
        check_val("t5_nohalt", {31'd0, s_halted}, 32'd0);
        step();
        check_val("t5_nojump2", {31'd0, s_jump}, 32'd0);

        // Jump beats memory hold.
        drive(0, 1, 32'h0000_0600, 0, 1, 0);
        step();
        check_val("t6_jump", {31'd0, s_jump}, 32'd1);
        check_val("t6_flush", {31'd0, s_flush}, 32'd1);
        check_val("t6_nohold", {31'd0, s_hold}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();

        // Randomized traffic with sticky ext/mem levels.
        ext_lvl = 0; mem_lvl = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(99) < 8)  ext_lvl = ~ext_lvl;
            if ($urandom_range(99) < 15) mem_lvl = ~mem_lvl;
            drive(($urandom_range(99) < 1), ($urandom_range(99) < 30), $urandom(),
                  ($urandom_range(99) < 15), mem_lvl, ext_lvl);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
